// File: rtl/audio_nios_cpu_oci_trace_capture.sv
// OCI debug-trace capture FIFO: stores {dct_count, dct_buffer} on dct_valid and drains through a registered read port.
// Define OCI_TRACE_WRAP_EN to overwrite the oldest entry when full; by default the newest entry is dropped.
module audio_nios_cpu_oci_trace_capture #(
    parameter int DATA_W  = 30,
    parameter int COUNT_W = 4,
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int DROP_W  = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [DATA_W-1:0]         dct_buffer,
    input  logic [COUNT_W-1:0]        dct_count,
    input  logic                      dct_valid,
    input  logic                      test_ending,
    input  logic                      test_has_ended,
    input  logic                      rd_req,
    output logic [COUNT_W+DATA_W-1:0] rd_data,
    output logic                      rd_valid,
    output logic [ADDR_W:0]           level,
    output logic                      empty,
    output logic                      full,
    output logic                      overflow,
    output logic [DROP_W-1:0]         drop_count,
    output logic [1:0]                state
);

    localparam int ENTRY_W = COUNT_W + DATA_W;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'b00,
        ST_DRAIN   = 2'b01,
        ST_DONE    = 2'b10
    } state_t;

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (&v) ? v : v + DROP_W'(1);
    endfunction

    state_t              r_state;
    logic [ENTRY_W-1:0]  r_mem [DEPTH];
    logic [ADDR_W-1:0]   r_head;
    logic [ADDR_W-1:0]   r_tail;
    logic [ADDR_W:0]     r_level;
    logic [ENTRY_W-1:0]  r_rd_data_p1;
    logic                r_vld_p1;
    logic                r_overflow;
    logic [DROP_W-1:0]   r_drop_count;

    logic w_empty;
    logic w_full;
    logic w_wr_req;
    logic w_rd_en;
    logic w_lost;
    logic w_push;
    logic w_overwrite;
    logic w_adv_head;

    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == (ADDR_W+1)'(DEPTH));
    assign w_wr_req = (r_state == ST_CAPTURE) && dct_valid;
    assign w_rd_en  = rd_req && !w_empty && (r_state != ST_DONE);
    // A read in the same cycle frees a slot, so a full FIFO only loses data without one.
    assign w_lost   = w_wr_req && w_full && !w_rd_en;

`ifdef OCI_TRACE_WRAP_EN
    assign w_push      = w_wr_req;
    assign w_overwrite = w_lost;
`else
    assign w_push      = w_wr_req && !w_lost;
    assign w_overwrite = 1'b0;
`endif

    assign w_adv_head = w_rd_en || w_overwrite;

    // Stage p0 -> p1: pointer/level bookkeeping, lifecycle FSM and registered read port.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_CAPTURE;
            r_head       <= '0;
            r_tail       <= '0;
            r_level      <= '0;
            r_rd_data_p1 <= '0;
            r_vld_p1     <= 1'b0;
            r_overflow   <= 1'b0;
            r_drop_count <= '0;
        end else begin
            unique case (r_state)
                ST_CAPTURE: begin
                    if (test_has_ended)   r_state <= ST_DONE;
                    else if (test_ending) r_state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    if (test_has_ended) r_state <= ST_DONE;
                end
                default: r_state <= ST_DONE;
            endcase

            if (w_push)
                r_tail <= r_tail + ADDR_W'(1);
            if (w_adv_head)
                r_head <= r_head + ADDR_W'(1);

            if (w_push && !w_adv_head)
                r_level <= r_level + (ADDR_W+1)'(1);
            else if (w_adv_head && !w_push)
                r_level <= r_level - (ADDR_W+1)'(1);

            if (w_rd_en)
                r_rd_data_p1 <= r_mem[r_head];
            r_vld_p1 <= w_rd_en;

            if (w_lost) begin
                r_overflow   <= 1'b1;
                r_drop_count <= sat_inc(r_drop_count);
            end
        end
    end

    // Storage carries no reset; validity is tracked entirely by the pointers and level.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_tail] <= {dct_count, dct_buffer};
    end

    assign rd_data    = r_rd_data_p1;
    assign rd_valid   = r_vld_p1;
    assign level      = r_level;
    assign empty      = w_empty;
    assign full       = w_full;
    assign overflow   = r_overflow;
    assign drop_count = r_drop_count;
    assign state      = r_state;

endmodule
